// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

   typedef enum logic {IDLE, OWN} arb_state_t;

   localparam int BURST_W = 4;

   // Grant index width; never narrower than one bit.
   function automatic int id_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority scan: first valid requester after the last owner,
// with the last owner itself examined last.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = id_w(N)
)(
   input  logic [N-1:0]  valid,
   input  logic [IW-1:0] last,
   output logic          found,
   output logic [IW-1:0] idx
);

   logic [IW-1:0] cand;

   // Walk from the farthest candidate to the nearest so the nearest valid one wins.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int k = N; k >= 1; k--) begin
         cand = IW'((int'(last) + k) % N);
         if (valid[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter for the sync FIFO write port.
// Define FIFO_ARB_STATS_EN to get saturating per-requester beat counters.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 6,
   parameter int NUM_REQ    = 2,
   parameter int MAX_BURST  = 4
)(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_dat,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          busy,
   output logic [NUM_REQ*8-1:0]          stat_cnt
);

   localparam int IW = id_w(NUM_REQ);

   arb_state_t         state, state_nxt;
   logic [IW-1:0]      owner, owner_nxt;
   logic [BURST_W-1:0] burst_cnt, burst_nxt;

   logic               keep;
   logic               pick_found;
   logic [IW-1:0]      pick_idx;
   logic               sel_found;
   logic [IW-1:0]      sel;
   logic               accept;

   rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
      .valid (req_valid),
      .last  (owner),
      .found (pick_found),
      .idx   (pick_idx)
   );

   assign keep      = (state == OWN) && req_valid[owner] && (burst_cnt < BURST_W'(MAX_BURST));
   assign sel_found = keep || pick_found;
   assign sel       = keep ? owner : pick_idx;

   // rst_n gates the datapath so nothing reaches the FIFO while reset is asserted.
   assign accept     = rst_n && sel_found && !fifo_full;
   assign fifo_wr_en = accept;
   assign grant_id   = owner;
   assign busy       = (state == OWN);

   always_comb begin
      req_ready = '0;
      fifo_dat  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (accept && (sel == IW'(i))) begin
            req_ready[i] = 1'b1;
            fifo_dat     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // A full FIFO freezes all arbitration state; a re-selection of the same owner restarts its tenure.
   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      burst_nxt = burst_cnt;
      if (!fifo_full) begin
         if (!sel_found) begin
            state_nxt = IDLE;
            burst_nxt = '0;
         end else if (keep) begin
            burst_nxt = burst_cnt + 1'b1;
         end else begin
            state_nxt = OWN;
            owner_nxt = sel;
            burst_nxt = BURST_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         owner     <= IW'(NUM_REQ - 1);
         burst_cnt <= '0;
      end else begin
         state     <= state_nxt;
         owner     <= owner_nxt;
         burst_cnt <= burst_nxt;
      end
   end

`ifdef FIFO_ARB_STATS_EN
   logic [7:0] stat_q [NUM_REQ];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i] && req_valid[i] && (stat_q[i] != 8'hFF))
               stat_q[i] <= stat_q[i] + 8'd1;
         end
      end
   end

   always_comb begin
      stat_cnt = '0;
      for (int i = 0; i < NUM_REQ; i++) stat_cnt[i*8 +: 8] = stat_q[i];
   end
`else
   assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random
// traffic, all compared against a transaction-level model of the arbitration rules.
module tb_fifo_wr_arbiter;

   localparam int DW = 6;
   localparam int N  = 2;
   localparam int MB = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]  req_ready;
   logic          fifo_full;
   logic          fifo_wr_en;
   logic [DW-1:0] fifo_dat;
   logic [$clog2(N)-1:0] grant_id;
   logic          busy;
   logic [N*8-1:0] stat_cnt;

   int total = 0;
   int bad   = 0;

   // Model state: who owns the port, whether a tenure is live, beats in it, totals.
   int m_owner;
   bit m_own;
   int m_beats;
   int m_stat [N];

   logic          obs_wr;
   logic [DW-1:0] obs_dat;
   logic [N-1:0]  obs_ready;
   int            obs_gid;
   bit            obs_busy;
   int            obs_stat0;

   fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .MAX_BURST(MB)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .fifo_full  (fifo_full),
      .fifo_wr_en (fifo_wr_en),
      .fifo_dat   (fifo_dat),
      .grant_id   (grant_id),
      .busy       (busy),
      .stat_cnt   (stat_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic modelReset();
      m_owner = N - 1;
      m_own   = 1'b0;
      m_beats = 0;
      for (int i = 0; i < N; i++) m_stat[i] = 0;
   endtask

   // Owner keeps the port while valid and under budget; otherwise the next valid after it wins.
   function automatic int modelPick(input logic [N-1:0] v);
      if (m_own && v[m_owner] && (m_beats < MB)) return m_owner;
      for (int k = 1; k <= N; k++) begin
         if (v[(m_owner + k) % N]) return (m_owner + k) % N;
      end
      return -1;
   endfunction

   function automatic int expStat(input int i);
`ifdef FIFO_ARB_STATS_EN
      return m_stat[i];
`else
      return 0;
`endif
   endfunction

   // One clock: drive at negedge, check combinational outputs, then advance the model at posedge.
   task automatic applyStimulus(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic full);
      int            sel;
      logic          ew;
      logic [N-1:0]  er;
      logic [DW-1:0] ed;
      logic [N*8-1:0] es;
      @(negedge clk);
      req_valid = v;
      req_data  = d;
      fifo_full = full;
      #1;
      sel = modelPick(v);
      ew  = (sel >= 0) && !full;
      er  = '0;
      ed  = '0;
      if (ew) begin
         er[sel] = 1'b1;
         ed      = d[sel*DW +: DW];
      end
      es = '0;
      for (int i = 0; i < N; i++) es[i*8 +: 8] = 8'(expStat(i));
      checkOutput("ready",    32'(req_ready),  32'(er));
      checkOutput("wr_en",    32'(fifo_wr_en), 32'(ew));
      checkOutput("dat",      32'(fifo_dat),   32'(ed));
      checkOutput("grant_id", 32'(grant_id),   32'(m_owner));
      checkOutput("busy",     32'(busy),       32'(m_own));
      checkOutput("stat",     32'(stat_cnt),   32'(es));
      obs_wr    = fifo_wr_en;
      obs_dat   = fifo_dat;
      obs_ready = req_ready;
      obs_gid   = int'(grant_id);
      obs_busy  = busy;
      obs_stat0 = int'(stat_cnt[7:0]);
      @(posedge clk);
      if (ew) begin
         if (m_own && (sel == m_owner) && (m_beats < MB)) begin
            m_beats++;
         end else begin
            m_own   = 1'b1;
            m_owner = sel;
            m_beats = 1;
         end
         if (m_stat[sel] < 255) m_stat[sel]++;
      end else if (!full) begin
         m_own   = 1'b0;
         m_beats = 0;
      end
   endtask

   task automatic doReset();
      rst_n     = 1'b0;
      req_valid = '0;
      fifo_full = 1'b0;
      modelReset();
      @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      logic [N-1:0]    rv;
      logic [N*DW-1:0] rd;
      logic            rf;

      // Reset with both requesters pending: nothing may leak out.
      rst_n     = 1'b0;
      req_valid = 2'b11;
      req_data  = {6'd9, 6'd5};
      fifo_full = 1'b0;
      modelReset();
      #12;
      checkOutput("rst_ready", 32'(req_ready),  32'd0);
      checkOutput("rst_wr_en", 32'(fifo_wr_en), 32'd0);
      checkOutput("rst_dat",   32'(fifo_dat),   32'd0);
      checkOutput("rst_gid",   32'(grant_id),   32'd1);
      checkOutput("rst_busy",  32'(busy),       32'd0);
      checkOutput("rst_stat",  32'(stat_cnt),   32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      applyStimulus(2'b11, {6'd9, 6'd5}, 1'b0);
      checkOutput("first_dat", 32'(obs_dat), 32'd5);

      $display("[TB] solo requester, tenure restart");
      doReset();
      for (int k = 1; k <= 6; k++) begin
         applyStimulus(2'b01, {6'd0, 6'(k)}, 1'b0);
         checkOutput("solo_wr",  32'(obs_wr),  32'd1);
         checkOutput("solo_dat", 32'(obs_dat), 32'(k));
      end

      $display("[TB] both valid, bursts of four");
      doReset();
      for (int k = 0; k < 12; k++) begin
         applyStimulus(2'b11, {6'd9, 6'd5}, 1'b0);
         checkOutput("rr_dat", 32'(obs_dat), ((k / 4) % 2 == 0) ? 32'd5 : 32'd9);
      end

      $display("[TB] full stall mid-burst");
      doReset();
      applyStimulus(2'b11, {6'd9, 6'd5}, 1'b0);
      applyStimulus(2'b11, {6'd9, 6'd5}, 1'b0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(2'b11, {6'd9, 6'd5}, 1'b1);
         checkOutput("full_wr",    32'(obs_wr),    32'd0);
         checkOutput("full_ready", 32'(obs_ready), 32'd0);
      end
      applyStimulus(2'b11, {6'd9, 6'd5}, 1'b0);
      checkOutput("resume_b3", 32'(obs_dat), 32'd5);
      applyStimulus(2'b11, {6'd9, 6'd5}, 1'b0);
      checkOutput("resume_b4", 32'(obs_dat), 32'd5);
      applyStimulus(2'b11, {6'd9, 6'd5}, 1'b0);
      checkOutput("resume_r1", 32'(obs_dat), 32'd9);

      $display("[TB] owner drops valid");
      doReset();
      applyStimulus(2'b10, {6'd9, 6'd5}, 1'b0);
      applyStimulus(2'b10, {6'd9, 6'd5}, 1'b0);
      checkOutput("drop_r1dat", 32'(obs_dat), 32'd9);
      applyStimulus(2'b01, {6'd9, 6'd5}, 1'b0);
      checkOutput("drop_ready", 32'(obs_ready), 32'd1);
      checkOutput("drop_busy",  32'(obs_busy),  32'd1);
      applyStimulus(2'b01, {6'd9, 6'd5}, 1'b0);
      checkOutput("drop_gid",   32'(obs_gid),   32'd0);
      checkOutput("drop_busy2", 32'(obs_busy),  32'd1);

      $display("[TB] async reset mid-burst, stat saturation");
      doReset();
      applyStimulus(2'b01, {6'd0, 6'd3}, 1'b0);
      applyStimulus(2'b01, {6'd0, 6'd4}, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("pulse_ready", 32'(req_ready),  32'd0);
      checkOutput("pulse_wr_en", 32'(fifo_wr_en), 32'd0);
      checkOutput("pulse_dat",   32'(fifo_dat),   32'd0);
      checkOutput("pulse_busy",  32'(busy),       32'd0);
      checkOutput("pulse_gid",   32'(grant_id),   32'd1);
      checkOutput("pulse_stat",  32'(stat_cnt),   32'd0);
      doReset();
      for (int k = 0; k < 300; k++) applyStimulus(2'b01, {6'd0, 6'(k)}, 1'b0);
`ifdef FIFO_ARB_STATS_EN
      checkOutput("stat_sat", 32'(obs_stat0), 32'd255);
`else
      checkOutput("stat_sat", 32'(obs_stat0), 32'd0);
`endif

      $display("[TB] random traffic");
      doReset();
      rv = '0;
      rd = '0;
      for (int c = 0; c < 500; c++) begin
         rf = ($urandom_range(0, 3) == 0);
         applyStimulus(rv, rd, rf);
         for (int i = 0; i < N; i++) begin
            if (rv[i] && obs_ready[i]) begin
               rv[i] = $urandom_range(0, 1) != 0;
               rd[i*DW +: DW] = DW'($urandom);
            end else if (!rv[i] && ($urandom_range(0, 1) != 0)) begin
               rv[i] = 1'b1;
               rd[i*DW +: DW] = DW'($urandom);
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
